dcm_lock_supervisor: RTL and testbench

DCM_LOCK_SUPERVISOR -- requirements
Module: dcm_lock_supervisor

---
 rtl/dcm_lock_supervisor.sv | 232 +++++++++++++++++++++++
 tb/tb_dcm_lock_supervisor.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcm_lock_supervisor.sv
// Supervises NUM_CH DCMs: waits for each LOCKED, filters it, and pulses the DCM
// reset on lock timeout, declaring a per-channel fault once retries run out.
module dcm_lock_supervisor #(
  parameter int NUM_CH          = 3,
  parameter int TICK_DIV        = 2,
  parameter int TIMEOUT_TICKS   = 50000,
  parameter int RST_PULSE_TICKS = 10,
  parameter int LOCK_FILTER     = 4,
  parameter int MAX_RETRIES     = 15
) (
  input  logic                  input_clk,
  input  logic                  reset_n,
  input  logic [NUM_CH-1:0]     dcm_locked_in,
  input  logic [NUM_CH-1:0]     channel_enable,
  input  logic                  clear_fault,
  output logic [NUM_CH-1:0]     dcm_reset_out,
  output logic [NUM_CH-1:0]     channel_ready,
  output logic                  all_ready,
  output logic [NUM_CH-1:0]     fault,
  output logic                  any_fault,
  output logic [4*NUM_CH-1:0]   retry_count
);

  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam int FW = $clog2(LOCK_FILTER + 1);
  localparam int PW = $clog2(RST_PULSE_TICKS + 1);
  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_FILTER    = 3'd2,
    ST_READY     = 3'd3,
    ST_PULSE     = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  logic [DW-1:0]     div_cnt;
  logic              tick;
  logic [NUM_CH-1:0] sync_meta;
  logic [NUM_CH-1:0] sync_lock;

  state_t        state_q  [NUM_CH];
  state_t        state_d  [NUM_CH];
  logic [TW-1:0] timer_q  [NUM_CH];
  logic [TW-1:0] timer_d  [NUM_CH];
  logic [FW-1:0] filter_q [NUM_CH];
  logic [FW-1:0] filter_d [NUM_CH];
  logic [PW-1:0] pulse_q  [NUM_CH];
  logic [PW-1:0] pulse_d  [NUM_CH];
  logic [3:0]    retry_q  [NUM_CH];
  logic [3:0]    retry_d  [NUM_CH];

  // The timer saturates so a long lock-high stretch in FILTER cannot wrap it.
  function automatic logic [TW-1:0] timer_step(input logic [TW-1:0] t);
    return (t == TW'(TIMEOUT_TICKS)) ? t : t + TW'(1);
  endfunction

  function automatic logic [3:0] retry_step(input logic [3:0] r);
    return (r == 4'hF) ? r : r + 4'd1;
  endfunction

  // Tick is registered, so the first one is consumed TICK_DIV edges after release.
  always_ff @(posedge input_clk) begin
    if (!reset_n) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_cnt == DW'(TICK_DIV - 1)) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + DW'(1);
      tick    <= 1'b0;
    end
  end

  always_ff @(posedge input_clk) begin
    if (!reset_n) begin
      sync_meta <= '0;
      sync_lock <= '0;
    end else begin
      sync_meta <= dcm_locked_in;
      sync_lock <= sync_meta;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i]  = state_q[i];
      timer_d[i]  = timer_q[i];
      filter_d[i] = filter_q[i];
      pulse_d[i]  = pulse_q[i];
      retry_d[i]  = retry_q[i];

      if (!channel_enable[i]) begin
        state_d[i]  = ST_IDLE;
        timer_d[i]  = '0;
        filter_d[i] = '0;
        pulse_d[i]  = '0;
        retry_d[i]  = '0;
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            state_d[i]  = ST_WAIT_LOCK;
            timer_d[i]  = '0;
            filter_d[i] = '0;
          end
          ST_WAIT_LOCK: begin
            if (tick) begin
              if (sync_lock[i]) begin
                filter_d[i] = FW'(1);
                state_d[i]  = (LOCK_FILTER == 1) ? ST_READY : ST_FILTER;
              end else begin
                timer_d[i] = timer_step(timer_q[i]);
                if (timer_step(timer_q[i]) == TW'(TIMEOUT_TICKS)) begin
                  if ((MAX_RETRIES != 0) && (int'(retry_q[i]) == MAX_RETRIES)) begin
                    state_d[i] = ST_FAULT;
                  end else begin
                    state_d[i] = ST_PULSE;
                    pulse_d[i] = '0;
                    retry_d[i] = retry_step(retry_q[i]);
                  end
                end
              end
            end
          end
          ST_FILTER: begin
            if (tick) begin
              timer_d[i] = timer_step(timer_q[i]);
              if (sync_lock[i]) begin
                filter_d[i] = filter_q[i] + FW'(1);
                if (int'(filter_q[i]) + 1 == LOCK_FILTER) begin
                  state_d[i] = ST_READY;
                end
              end else begin
                // Lock dropped: restart filtering but keep the timeout running.
                filter_d[i] = '0;
                if (timer_step(timer_q[i]) == TW'(TIMEOUT_TICKS)) begin
                  if ((MAX_RETRIES != 0) && (int'(retry_q[i]) == MAX_RETRIES)) begin
                    state_d[i] = ST_FAULT;
                  end else begin
                    state_d[i] = ST_PULSE;
                    pulse_d[i] = '0;
                    retry_d[i] = retry_step(retry_q[i]);
                  end
                end else begin
                  state_d[i] = ST_WAIT_LOCK;
                end
              end
            end
          end
          ST_READY: begin
            if (tick && !sync_lock[i]) begin
              state_d[i]  = ST_WAIT_LOCK;
              timer_d[i]  = '0;
              filter_d[i] = '0;
            end
          end
          ST_PULSE: begin
            if (tick) begin
              if (int'(pulse_q[i]) + 1 == RST_PULSE_TICKS) begin
                state_d[i]  = ST_WAIT_LOCK;
                timer_d[i]  = '0;
                filter_d[i] = '0;
                pulse_d[i]  = '0;
              end else begin
                pulse_d[i] = pulse_q[i] + PW'(1);
              end
            end
          end
          ST_FAULT: begin
            if (clear_fault) begin
              state_d[i] = ST_PULSE;
              pulse_d[i] = '0;
              retry_d[i] = 4'd1;
            end
          end
          default: begin
            state_d[i] = ST_WAIT_LOCK;
            timer_d[i] = '0;
          end
        endcase
      end
    end
  end

  // Per-channel outputs are registered from the next state so they move on the
  // same edge as the state itself.
  always_ff @(posedge input_clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]  <= ST_WAIT_LOCK;
        timer_q[i]  <= '0;
        filter_q[i] <= '0;
        pulse_q[i]  <= '0;
        retry_q[i]  <= '0;
      end
      dcm_reset_out <= '0;
      channel_ready <= '0;
      fault         <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]       <= state_d[i];
        timer_q[i]       <= timer_d[i];
        filter_q[i]      <= filter_d[i];
        pulse_q[i]       <= pulse_d[i];
        retry_q[i]       <= retry_d[i];
        dcm_reset_out[i] <= (state_d[i] == ST_PULSE) || (state_d[i] == ST_IDLE);
        channel_ready[i] <= (state_d[i] == ST_READY);
        fault[i]         <= (state_d[i] == ST_FAULT);
      end
    end
  end

  always_ff @(posedge input_clk) begin
    if (!reset_n) begin
      all_ready <= 1'b0;
      any_fault <= 1'b0;
    end else begin
      all_ready <= (|channel_enable) && ((channel_ready | ~channel_enable) == '1);
      any_fault <= |fault;
    end
  end

  always_comb begin
    retry_count = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      retry_count[4*i +: 4] = retry_q[i];
    end
  end

endmodule

// File: tb/tb_dcm_lock_supervisor.sv
// Scenario bench for dcm_lock_supervisor: expected values are queued when a
// scenario starts and popped as the matching DUT behaviour is observed.
module tb_dcm_lock_supervisor;

  localparam int NUM_CH          = 2;
  localparam int TICK_DIV        = 2;
  localparam int TIMEOUT_TICKS   = 20;
  localparam int RST_PULSE_TICKS = 3;
  localparam int LOCK_FILTER     = 4;
  localparam int MAX_RETRIES     = 2;
  localparam int W               = 32;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [NUM_CH-1:0]   dcm_locked_in;
  logic [NUM_CH-1:0]   channel_enable;
  logic                clear_fault;
  logic [NUM_CH-1:0]   dcm_reset_out;
  logic [NUM_CH-1:0]   channel_ready;
  logic                all_ready;
  logic [NUM_CH-1:0]   fault;
  logic                any_fault;
  logic [4*NUM_CH-1:0] retry_count;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;
  logic [W-1:0] obs;
  int n_total = 0;
  int n_bad   = 0;

  dcm_lock_supervisor #(
    .NUM_CH(NUM_CH), .TICK_DIV(TICK_DIV), .TIMEOUT_TICKS(TIMEOUT_TICKS),
    .RST_PULSE_TICKS(RST_PULSE_TICKS), .LOCK_FILTER(LOCK_FILTER), .MAX_RETRIES(MAX_RETRIES)
  ) dut (
    .input_clk(clk), .reset_n(reset_n), .dcm_locked_in(dcm_locked_in),
    .channel_enable(channel_enable), .clear_fault(clear_fault),
    .dcm_reset_out(dcm_reset_out), .channel_ready(channel_ready), .all_ready(all_ready),
    .fault(fault), .any_fault(any_fault), .retry_count(retry_count)
  );

  always #5 clk = ~clk;

  // Snapshot: [15:14] rst, [13:12] ready, [11:10] fault, [9] all_ready, [8] any_fault, [7:0] retry.
  function automatic logic [15:0] snap();
    return {dcm_reset_out, channel_ready, fault, all_ready, any_fault, retry_count};
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns #1 after the last reset edge; the next edge is the first with reset_n high.
  task automatic apply_reset(input logic [1:0] en, input logic [1:0] lock);
    reset_n        = 1'b0;
    channel_enable = en;
    dcm_locked_in  = lock;
    clear_fault    = 1'b0;
    wait_cycles(3);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    channel_enable = 2'b11;
    clear_fault    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dcm_locked_in = 2'($urandom_range(0, 3));
      clear_fault   = 1'($urandom_range(0, 1));
      exp_q.push_back(W'(16'h0000));
      wait_cycles(1);
      exp_v = exp_q.pop_front(); obs = W'(snap()); n_total++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL reset_snap got=%h exp=%h", obs, exp_v); end
    end
    clear_fault = 1'b0;
  endtask

  task automatic test_disabled();
    exp_q.push_back(W'(16'hC000));
    exp_q.push_back(W'(16'hC000));
    apply_reset(2'b00, 2'b11);
    wait_cycles(1);
    exp_v = exp_q.pop_front(); obs = W'(snap()); n_total++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL idle_after_release got=%h exp=%h", obs, exp_v); end
    wait_cycles(30);
    exp_v = exp_q.pop_front(); obs = W'(snap()); n_total++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL none_enabled got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_timeout_retry();
    int r0 = -1, r1 = -1, f0 = -1, fault_at = -1, n_rise = 0;
    logic [3:0] ret0 = 4'hx, ret1 = 4'hx;
    logic af0 = 1'bx, af1 = 1'bx, prev_rst = 1'b0;
    exp_q.push_back(W'(TIMEOUT_TICKS * TICK_DIV));
    exp_q.push_back(W'(RST_PULSE_TICKS * TICK_DIV));
    exp_q.push_back(W'(1));
    exp_q.push_back(W'((2 * TIMEOUT_TICKS + RST_PULSE_TICKS) * TICK_DIV));
    exp_q.push_back(W'(2));
    exp_q.push_back(W'((3 * TIMEOUT_TICKS + 2 * RST_PULSE_TICKS) * TICK_DIV));
    exp_q.push_back(W'(0));
    exp_q.push_back(W'(1));
    exp_q.push_back(W'(16'h8502));
    exp_q.push_back(W'(16'hC101));
    exp_q.push_back(W'(16'hC001));
    exp_q.push_back(W'(16'h0000));
    apply_reset(2'b01, 2'b00);
    for (int k = 0; k < 200; k++) begin
      wait_cycles(1);
      if (dcm_reset_out[0] && !prev_rst) begin
        n_rise++;
        if (n_rise == 1) begin r0 = k; ret0 = retry_count[3:0]; end
        else if (n_rise == 2) begin r1 = k; ret1 = retry_count[3:0]; end
      end
      if (!dcm_reset_out[0] && prev_rst && f0 < 0) f0 = k;
      if (fault[0] && fault_at < 0) begin fault_at = k; af0 = any_fault; end
      if (fault_at >= 0 && k == fault_at + 1) af1 = any_fault;
      prev_rst = dcm_reset_out[0];
    end
    exp_v = exp_q.pop_front(); obs = W'(r0); n_total++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL pulse1_start got=%0d exp=%0d", obs, exp_v); end
    exp_v = exp_q.pop_front(); obs = W'(f0 - r0); n_total++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL pulse1_width got=%0d exp=%0d", obs, exp_v); end
    exp_v = exp_q.pop_front(); obs = W'(ret0); n_total++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL retry_after_pulse1 got=%0d exp=%0d", obs, exp_v); end
    exp_v = exp_q.pop_front(); obs = W'(r1); n_total++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL pulse2_start got=%0d exp=%0d", obs, exp_v); end
    exp_v = exp_q.pop_front(); obs = W'(ret1); n_total++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL retry_after_pulse2 got=%0d exp=%0d", obs, exp_v); end
    exp_v = exp_q.pop_front(); obs = W'(fault_at); n_total++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL fault_cycle got=%0d exp=%0d", obs, exp_v); end
    exp_v = exp_q.pop_front(); obs = W'(af0); n_total++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL any_fault_same_cycle got=%0d exp=%0d", obs, exp_v); end
    exp_v = exp_q.pop_front(); obs = W'(af1); n_total++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL any_fault_next_cycle got=%0d exp=%0d", obs, exp_v); end
    exp_v = exp_q.pop_front(); obs = W'(snap()); n_total++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL fault_held_no_pulse got=%h exp=%h (rises=%0d)", obs, exp_v, n_rise); end

    clear_fault = 1'b1;
    wait_cycles(1);
    clear_fault = 1'b0;
    exp_v = exp_q.pop_front(); obs = W'(snap()); n_total++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL clear_to_pulse got=%h exp=%h", obs, exp_v); end
    wait_cycles(1);
    exp_v = exp_q.pop_front(); obs = W'(snap()); n_total++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL any_fault_clears got=%h exp=%h", obs, exp_v); end

    reset_n = 1'b0;
    wait_cycles(1);
    exp_v = exp_q.pop_front(); obs = W'(snap()); n_total++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL reset_mid_pulse got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_lock_ready();
    int rdy_at = -1, fall_at = -1;
    logic ar0 = 1'bx, ar1 = 1'bx, arf0 = 1'bx, arf1 = 1'bx;
    logic recovered = 1'b0, saw_pulse = 1'b0, done = 1'b0;
    exp_q.push_back(W'(LOCK_FILTER * TICK_DIV));
    exp_q.push_back(W'(0));
    exp_q.push_back(W'(1));
    exp_q.push_back(W'(16'h6200));
    exp_q.push_back(W'(1));
    exp_q.push_back(W'(1));
    exp_q.push_back(W'(0));
    exp_q.push_back(W'(1));
    exp_q.push_back(W'(0));
    exp_q.push_back(W'(0));
    apply_reset(2'b10, 2'b10);
    for (int k = 0; k < 60 && !done; k++) begin
      wait_cycles(1);
      if (channel_ready[1] && rdy_at < 0) begin rdy_at = k; ar0 = all_ready; end
      else if (rdy_at >= 0 && k == rdy_at + 1) begin ar1 = all_ready; done = 1'b1; end
    end
    exp_v = exp_q.pop_front(); obs = W'(rdy_at); n_total++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL ready_cycle got=%0d exp=%0d", obs, exp_v); end
    exp_v = exp_q.pop_front(); obs = W'(ar0); n_total++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL all_ready_lag got=%0d exp=%0d", obs, exp_v); end
    exp_v = exp_q.pop_front(); obs = W'(ar1); n_total++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL all_ready_rise got=%0d exp=%0d", obs, exp_v); end
    exp_v = exp_q.pop_front(); obs = W'(snap()); n_total++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL ready_snapshot got=%h exp=%h", obs, exp_v); end

    dcm_locked_in = 2'b00;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      wait_cycles(1);
      if (!channel_ready[1] && fall_at < 0) begin fall_at = k; arf0 = all_ready; end
      else if (fall_at >= 0 && k == fall_at + 1) begin arf1 = all_ready; done = 1'b1; end
    end
    exp_v = exp_q.pop_front(); obs = W'(fall_at >= 0); n_total++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL ready_drop got=%0d exp=%0d", obs, exp_v); end
    exp_v = exp_q.pop_front(); obs = W'(arf0); n_total++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL all_ready_fall_lag got=%0d exp=%0d", obs, exp_v); end
    exp_v = exp_q.pop_front(); obs = W'(arf1); n_total++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL all_ready_fall got=%0d exp=%0d", obs, exp_v); end

    dcm_locked_in = 2'b10;
    for (int k = 0; k < 30 && !recovered; k++) begin
      wait_cycles(1);
      if (dcm_reset_out[1]) saw_pulse = 1'b1;
      if (channel_ready[1]) recovered = 1'b1;
    end
    exp_v = exp_q.pop_front(); obs = W'(recovered); n_total++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL ready_recovery got=%0d exp=%0d", obs, exp_v); end
    exp_v = exp_q.pop_front(); obs = W'(saw_pulse); n_total++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL recovery_pulse got=%0d exp=%0d", obs, exp_v); end
    exp_v = exp_q.pop_front(); obs = W'(retry_count); n_total++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL recovery_retry got=%h exp=%h", obs, exp_v); end
  endtask

  // Drives lock[0] so tick j+1 samples pat[j]; the last pattern bit is held.
  task automatic run_pattern(input logic [15:0] pat, input int npat, input int budget,
                             output int ready_at, output int pulse_at);
    int idx;
    ready_at = -1;
    pulse_at = -1;
    apply_reset(2'b01, {1'b0, pat[0]});
    for (int k = 0; k < budget; k++) begin
      wait_cycles(1);
      if (channel_ready[0] && ready_at < 0) ready_at = k;
      if (dcm_reset_out[0] && pulse_at < 0) pulse_at = k;
      if (k % 2 == 1) begin
        idx = (k + 1) / 2;
        dcm_locked_in = {1'b0, (idx < npat) ? pat[idx] : pat[npat - 1]};
      end
    end
  endtask

  task automatic test_filter_glitch();
    int ready_at, pulse_at;
    exp_q.push_back(W'((3 + LOCK_FILTER) * TICK_DIV));
    exp_q.push_back(W'(-1));
    exp_q.push_back(W'(-1));
    exp_q.push_back(W'((TIMEOUT_TICKS + 2) * TICK_DIV));
    // Ticks: H H L H H H H -> filter restarts at tick 4 and completes at tick 7.
    run_pattern(16'b1111011, 7, 40, ready_at, pulse_at);
    exp_v = exp_q.pop_front(); obs = W'(ready_at); n_total++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL glitch_ready_cycle got=%0d exp=%0d", obs, exp_v); end
    exp_v = exp_q.pop_front(); obs = W'(pulse_at); n_total++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL glitch_no_pulse got=%0d exp=%0d", obs, exp_v); end
    // Ticks: H H L H H L then low: timer advances on every tick except the two WAIT->FILTER ones.
    run_pattern(16'b011011, 6, 60, ready_at, pulse_at);
    exp_v = exp_q.pop_front(); obs = W'(ready_at); n_total++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL glitch_never_ready got=%0d exp=%0d", obs, exp_v); end
    exp_v = exp_q.pop_front(); obs = W'(pulse_at); n_total++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL glitch_timer_kept got=%0d exp=%0d", obs, exp_v); end
  endtask

  task automatic test_disable_mid_pulse();
    int pulse_at = -1;
    exp_q.push_back(W'(TIMEOUT_TICKS * TICK_DIV));
    exp_q.push_back(W'(16'hC000));
    exp_q.push_back(W'(16'hC000));
    exp_q.push_back(W'(16'h8000));
    apply_reset(2'b01, 2'b00);
    for (int k = 0; k < 100 && pulse_at < 0; k++) begin
      wait_cycles(1);
      if (dcm_reset_out[0]) pulse_at = k;
    end
    exp_v = exp_q.pop_front(); obs = W'(pulse_at); n_total++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL dis_pulse_start got=%0d exp=%0d", obs, exp_v); end
    wait_cycles(2);
    channel_enable = 2'b00;
    wait_cycles(1);
    exp_v = exp_q.pop_front(); obs = W'(snap()); n_total++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL dis_mid_pulse got=%h exp=%h", obs, exp_v); end
    wait_cycles(10);
    exp_v = exp_q.pop_front(); obs = W'(snap()); n_total++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL dis_idle_hold got=%h exp=%h", obs, exp_v); end
    channel_enable = 2'b01;
    wait_cycles(1);
    exp_v = exp_q.pop_front(); obs = W'(snap()); n_total++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL reenable_wait got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_back_to_back();
    int fault_at = -1;
    exp_q.push_back(W'((3 * TIMEOUT_TICKS + 2 * RST_PULSE_TICKS) * TICK_DIV));
    exp_q.push_back(W'(16'hC100));
    apply_reset(2'b01, 2'b00);
    for (int k = 0; k < 200 && fault_at < 0; k++) begin
      wait_cycles(1);
      if (fault[0]) fault_at = k;
    end
    exp_v = exp_q.pop_front(); obs = W'(fault_at); n_total++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL b2b_fault_cycle got=%0d exp=%0d", obs, exp_v); end
    // Disable and clear on the same cycle: disable wins, so retry_count is 0, not 1.
    channel_enable = 2'b00;
    clear_fault    = 1'b1;
    wait_cycles(1);
    clear_fault = 1'b0;
    exp_v = exp_q.pop_front(); obs = W'(snap()); n_total++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL disable_beats_clear got=%h exp=%h", obs, exp_v); end
  endtask

  initial begin
    reset_n        = 1'b0;
    dcm_locked_in  = '0;
    channel_enable = '0;
    clear_fault    = 1'b0;
    test_reset();
    test_disabled();
    test_timeout_retry();
    test_lock_ready();
    test_filter_glitch();
    test_disable_mid_pulse();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
